wb_cmd_master: RTL and testbench

// Wishbone classic initiator: drives the register slaves (diff-pair polarity control, etc.) from a command stream.

---
 rtl/wb_cmd_master.sv | 138 +++++++++++++
 tb/tb_wb_cmd_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: queues {we, adr, dat, sel} commands and runs one single-beat cycle per command.
// Optional bus timeout abort is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_tout_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    state_t        state, state_nxt;
    logic          push, pop, done, tout_hit;

    // Full blocks pushes even when a pop happens the same cycle
    assign cmd_ready_o = (count != (AW+1)'(DEPTH));
    assign push        = cmd_valid_i & cmd_ready_o;
    assign wb_cyc_o    = (state == BUS);
    assign wb_stb_o    = wb_cyc_o;
    assign rsp_valid_o = (state == RESP);

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= '{cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;

    assign tout_hit = (state == BUS) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            tcnt <= '0;
        else if (pop)
            tcnt <= '0;
        else if (state == BUS && !wb_ack_i && !wb_err_i)
            tcnt <= tcnt + TW'(1);
    end
`else
    assign tout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop       = 1'b1;
                state_nxt = BUS;
            end
            BUS: if (wb_ack_i || wb_err_i || tout_hit) begin
                done      = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // err dominates ack; ack on the abort cycle beats the timeout
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            rsp_dat_o  <= '0;
            rsp_err_o  <= 1'b0;
            rsp_tout_o <= 1'b0;
        end else begin
            if (pop) begin
                wb_we_o  <= mem[rd_ptr].we;
                wb_adr_o <= mem[rd_ptr].adr;
                wb_dat_o <= mem[rd_ptr].dat;
                wb_sel_o <= mem[rd_ptr].sel;
            end
            if (done) begin
                rsp_dat_o  <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : 32'h0;
                rsp_err_o  <= wb_err_i | (tout_hit & ~wb_ack_i);
                rsp_tout_o <= tout_hit & ~wb_ack_i & ~wb_err_i;
            end
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: behavioural Wishbone slave, response recorder, hand-computed expectations.
module tb_wb_cmd_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_err, rsp_tout;
    logic [31:0] rsp_dat;
    logic [31:0] wb_adr, wb_dato, wb_dati = '0;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack = 1'b0, wb_err = 1'b0;

    wb_cmd_master #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_tout_o(rsp_tout),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dato), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
        .wb_dat_i(wb_dati), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic        err, tout;
        logic [31:0] adr, wdat;
        logic        we;
        logic [3:0]  sel;
        int          len;
        logic        stable, stb_ok;
    } rec_t;

    rec_t        rq[$];
    rec_t        cur;
    logic        in_bus = 1'b0;
    int          nstart = 0, wcnt = 0, lat = 0;
    logic        stall = 1'b0, sl_err = 1'b0, sl_both = 1'b0;
    logic [31:0] rdata = '0;
    int          nvec = 0, nmis = 0;

    // Slave and recorder: inputs change on the falling edge, DUT samples on the rising edge
    always @(negedge clk) begin
        wb_ack  = 1'b0;
        wb_err  = 1'b0;
        wb_dati = '0;
        if (wb_cyc) begin
            if (!in_bus) begin
                in_bus     = 1'b1;
                nstart     = nstart + 1;
                cur.adr    = wb_adr;
                cur.wdat   = wb_dato;
                cur.we     = wb_we;
                cur.sel    = wb_sel;
                cur.len    = 0;
                cur.stable = 1'b1;
                cur.stb_ok = 1'b1;
            end
            cur.len = cur.len + 1;
            if (wb_adr !== cur.adr || wb_dato !== cur.wdat || wb_we !== cur.we || wb_sel !== cur.sel)
                cur.stable = 1'b0;
            if (wb_stb !== 1'b1) cur.stb_ok = 1'b0;
            if (stall) wcnt = 0;
            else if (wcnt == lat) begin
                wcnt    = 0;
                wb_err  = sl_err | sl_both;
                wb_ack  = ~sl_err | sl_both;
                wb_dati = rdata;
            end else wcnt = wcnt + 1;
        end else begin
            in_bus = 1'b0;
            wcnt   = 0;
        end
        if (rsp_valid) begin
            cur.dat  = rsp_dat;
            cur.err  = rsp_err;
            cur.tout = rsp_tout;
            rq.push_back(cur);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_stuck", 32'(cmd_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic stop_push();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output rec_t r);
        int n = 0;
        while (rq.size() == 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rq.size() == 0) begin
            chk({tag, "_no_rsp"}, 32'd0, 32'd1);
            r = '{default: 0};
        end else r = rq.pop_front();
    endtask

    initial begin
        rec_t r;
        int   s0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outs", wb_adr | wb_dato | rsp_dat | 32'(wb_sel) | 32'({wb_we, rsp_err, rsp_tout}), 32'd0);
        rst = 1'b0;

        // 1) write, ack in second bus cycle; slave drives junk data that must not leak
        lat = 1; rdata = 32'hFFFF_FFFF;
        push(1'b1, 32'h10, 32'hA5, 4'hF);
        stop_push();
        wait_rsp("t1", r);
        chk("t1_we", 32'(r.we), 32'd1);
        chk("t1_wdat", r.wdat, 32'hA5);
        chk("t1_adr_sel", r.adr | 32'(r.sel) << 16, 32'h000F_0010);
        chk("t1_len", 32'(r.len), 32'd2);
        chk("t1_rsp", {r.dat[29:0], r.err, r.tout}, 32'd0);
        chk("t1_stb", 32'(r.stb_ok), 32'd1);
        @(negedge clk);
        chk("t1_one_strobe", 32'(rsp_valid), 32'd0);

        // 2) read with 3 wait states
        lat = 3; rdata = 32'h0000_00C3;
        push(1'b0, 32'h14, 32'h0, 4'hF);
        stop_push();
        wait_rsp("t2", r);
        chk("t2_len", 32'(r.len), 32'd4);
        chk("t2_stable", 32'(r.stable), 32'd1);
        chk("t2_adr", r.adr, 32'h14);
        chk("t2_dat", r.dat, 32'hC3);
        chk("t2_err", 32'(r.err), 32'd0);
        repeat (4) @(negedge clk);
        chk("t2_hold", rsp_dat, 32'hC3);

        // 3) five back-to-back pushes against a stalled slave: one in flight plus four queued
        stall = 1'b1; lat = 0;
        for (int i = 0; i < 5; i++) push(1'b1, 32'h100 + 32'(4 * i), 32'(i + 1), 4'h3);
        stop_push();
        chk("t3_full", 32'(cmd_ready), 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("t3", r);
            chk($sformatf("t3_adr%0d", i), r.adr, 32'h100 + 32'(4 * i));
            chk($sformatf("t3_wdat%0d", i), r.wdat, 32'(i + 1));
            chk($sformatf("t3_err%0d", i), 32'(r.err), 32'd0);
        end
        chk("t3_ready", 32'(cmd_ready), 32'd1);

        // 4) slave error on a read, then ack and err together
        lat = 1; sl_err = 1'b1; rdata = 32'hDEAD_BEEF;
        push(1'b0, 32'h20, 32'h0, 4'hF);
        stop_push();
        wait_rsp("t4", r);
        chk("t4_err", {30'd0, r.err, r.tout}, 32'd2);
        chk("t4_dat", r.dat, 32'd0);
        sl_err = 1'b0; sl_both = 1'b1; lat = 0;
        push(1'b0, 32'h24, 32'h0, 4'hF);
        stop_push();
        wait_rsp("t4b", r);
        chk("t4b_err", {30'd0, r.err, r.tout}, 32'd2);
        chk("t4b_dat", r.dat, 32'd0);
        sl_both = 1'b0;

        // 5) silent slave
        stall = 1'b1; rdata = 32'h55;
        push(1'b0, 32'h30, 32'h0, 4'hF);
        stop_push();
`ifdef WB_MASTER_TIMEOUT_EN
        wait_rsp("t5", r);
        chk("t5_len", 32'(r.len), 32'd8);
        chk("t5_err", {30'd0, r.err, r.tout}, 32'd3);
        chk("t5_dat", r.dat, 32'd0);
        stall = 1'b0;
`else
        repeat (110) @(negedge clk);
        chk("t5_cyc_held", 32'(wb_cyc), 32'd1);
        stall = 1'b0;
        wait_rsp("t5", r);
        chk("t5_err", {30'd0, r.err, r.tout}, 32'd0);
        chk("t5_dat", r.dat, 32'h55);
`endif

        // 6) reset during the second bus cycle with two commands queued
        stall = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 32'h200 + 32'(4 * i), 32'h0, 4'hF);
        stop_push();
        chk("t6_in_bus", 32'(wb_cyc), 32'd1);
        rst = 1'b1;
        s0  = nstart;
        @(negedge clk);
        chk("t6_cyc", {30'd0, wb_cyc, wb_stb}, 32'd0);
        chk("t6_ready", 32'(cmd_ready), 32'd1);
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        rst   = 1'b0;
        stall = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_fifo_empty", 32'(nstart - s0), 32'd0);
        chk("t6_no_rsp_q", 32'(rq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
